// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, FSM state encodings and parity helper.
// UART_RX_PARITY_EN adds the PARITY state encoding for 8E1 framing.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    ST_PARITY  = 3'd5
`endif
  } uart_state_e;

  // Even-parity bit for a data byte: 1 when the byte holds an odd number of ones.
  function automatic logic parity_even(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a parameter.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_simple.sv
// UART receiver, 8N1 by default; defining UART_RX_PARITY_EN switches to 8E1 with parity checking.
// Mid-bit sampling from a single start-edge alignment; pulses are registered and mutually exclusive.
//
// state   | meaning
// IDLE    | line idle, waiting for rx_s low
// START   | timing to mid start bit, rejects glitches
// DATA    | sampling 8 data bits LSB-first
// PARITY  | sampling even parity bit (UART_RX_PARITY_EN only)
// STOP    | sampling stop bit, reporting result
// RECOVER | after a framing error, waiting for the line to return high
module uart_rx_simple
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] CNT_MID  = 8'((CLKS_PER_BIT - 1) / 2);

  logic        rx_s;
  uart_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        dv_q, dv_d;
  logic        fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
  logic        pe_q, pe_d;
  logic        par_q, par_d;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      data_q    <= 8'd0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q      <= 1'b0;
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
`ifdef UART_RX_PARITY_EN
      pe_q      <= pe_d;
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    fe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_d      = 1'b0;
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d     = 8'd0;
        bit_idx_d = 3'd0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = 8'd0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = 8'd0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 8'd0;
          par_d   = rx_s;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = 8'd0;
          if (!rx_s) begin
            fe_d    = 1'b1;
            state_d = ST_RECOVER;
          end else begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_q != parity_even(shift_q)) begin
              pe_d = 1'b1;
            end else begin
              data_d = shift_q;
              dv_d   = 1'b1;
            end
`else
            data_d = shift_q;
            dv_d   = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RECOVER: begin
        // Only a high line releases us, so a held-low break never relocks.
        cnt_d = 8'd0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_simple.md
UART_RX_SIMPLE -- requirements
Module: uart_rx_simple

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning clocks per bit (115200 baud at 25 MHz).
REQ-002 SHALL have port clk  input  1  system clock, 25 MHz.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx  input  1  asynchronous UART line, idle high.
REQ-005 SHALL have port data  output  8  last good received byte.
REQ-006 SHALL have port data_valid  output  1  one-cycle pulse when data updates.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 without UART_RX_PARITY_EN.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (reset value 1); all logic uses the synchronized rx_s.
REQ-011 SHALL use the FSM states IDLE, START, DATA, PARITY (macro builds only), STOP and RECOVER.
REQ-012 IDLE: when rx_s is 0, SHALL go to START with clk_count=0.
REQ-013 START: at clk_count == (CLKS_PER_BIT-1)/2 (108), SHALL go to DATA with clk_count=0 if rx_s is 0; otherwise SHALL return to IDLE silently as a glitch, with no error.
REQ-014 DATA: at clk_count == CLKS_PER_BIT-1, SHALL shift rx_s in LSB-first and increment the 3-bit bit_index; after the 8th bit, SHALL go to STOP (or PARITY).
REQ-015 STOP: at clk_count == CLKS_PER_BIT-1, if rx_s is 1, SHALL load data from the shift register, pulse data_valid for exactly one cycle, and go to IDLE.
REQ-016 STOP: if rx_s is 0, SHALL pulse frame_err for one cycle, leave data unchanged, and go to RECOVER.
REQ-017 RECOVER: SHALL stay until rx_s is 1 (break or stuck-low line), then go to IDLE; it SHALL never relock on a held-low line.
REQ-018 data_valid, frame_err and parity_err SHALL be mutually exclusive in any cycle.
REQ-019 Latency: the pulse SHALL assert in the clock after the mid-stop sample, about 9.5 bit times (+2 sync cycles) after the start edge.
REQ-020 A new start bit SHALL be accepted the first cycle after returning to IDLE, with no dead time beyond that cycle (back-to-back frames).
REQ-021 clk_count SHALL be 8 bits and SHALL NOT wrap; CLKS_PER_BIT SHALL be ≤256.
REQ-022 data SHALL hold its value until the next good frame.

Reset
REQ-023 On rst_n low: state=IDLE, data=0x00, data_valid=0, frame_err=0, parity_err=0, busy=0, synchronizer=1, counters=0.
REQ-024 Reset mid-frame SHALL abandon the frame with no pulse; after release, reception SHALL resume at the next falling edge.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: frame SHALL be 8E1; after DATA, the PARITY state samples at clk_count == CLKS_PER_BIT-1.
REQ-026 With UART_RX_PARITY_EN, if the sampled bit differs from the XOR of the data bits (even parity), the block SHALL still sample the stop bit, then pulse parity_err instead of data_valid and leave data unchanged.
REQ-027 With UART_RX_PARITY_EN, a frame error SHALL take priority over a parity error.
REQ-028 Macro UART_RX_PARITY_EN undefined: frame SHALL be 8N1, the PARITY state SHALL be absent, and parity_err SHALL be constant 0.

Structure
REQ-029 Shared package uart_pkg SHALL hold CLKS_PER_BIT_DEFAULT, the state encodings, and the parity helper function, shared with the transmitter.
REQ-030 The synchronizer SHALL be a separate sub-module, sync_2ff (2 flops, reset value parameterized).

Verification
REQ-031 Send 0x46 in 8N1 at 217 clk/bit: data=0x46, one data_valid pulse about 2064 cycles after the start edge, busy low afterwards.
REQ-032 Send 0x55 then 0xAA back-to-back with no idle gap: two data_valid pulses, data=0x55 then 0xAA.
REQ-033 Drive a 50-cycle low glitch on idle rx: no pulses, busy returns low within 110 cycles.
REQ-034 Send 0x3C with the stop bit low, holding rx low for 3000 cycles, then high, then send 0x12: frame_err once, data stays at its previous value, no relock while low, then data=0x12.
REQ-035 Assert rst_n low at bit 4 of a frame: all outputs return to reset values; the next 0xA5 frame is received correctly.
REQ-036 With UART_RX_PARITY_EN, send 0x46 with parity bit 1: data_valid. Send 0x46 with parity bit 0: parity_err only, data unchanged.
